// File: rtl/mult_seq_32.sv
// Sequential signed 32x32 multiplier: sign-magnitude shift-and-add over 33 cycles,
// with every arithmetic step built from the 32-bit ripple-carry adder/subtractor.

module mult_seq_32_addsub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        co
);
    logic [31:0] bx;
    logic        carry;

    assign bx = b ^ {32{sub}};

    always_comb begin
        sum   = '0;
        carry = sub;
        for (int unsigned i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ bx[i] ^ carry;
            carry  = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
        end
        co = carry;
    end
endmodule

module mult_seq_32 (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        BUSY,
    output logic        DONE,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        START
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_SIGN
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplr_q, mplr_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [31:0] neg_a, neg_b, step_sum, neg_lo, neg_hi;
    logic        co_na, co_nb, step_co, co_lo, co_hi;
    logic        mplr_zero;
    logic        unused_carries;

    // Operand magnitudes: 0 - x
    mult_seq_32_addsub u_mag_a (
        .a  ('0),
        .b  (A),
        .sub(1'b1),
        .sum(neg_a),
        .co (co_na)
    );

    mult_seq_32_addsub u_mag_b (
        .a  ('0),
        .b  (B),
        .sub(1'b1),
        .sum(neg_b),
        .co (co_nb)
    );

    mult_seq_32_addsub u_step (
        .a  (acc_q),
        .b  (mcand_q),
        .sub(1'b0),
        .sum(step_sum),
        .co (step_co)
    );

    // 64-bit negate split: low word borrows into the high word only when it is zero
    assign mplr_zero = (mplr_q == '0);

    mult_seq_32_addsub u_neg_lo (
        .a  ('0),
        .b  (mplr_q),
        .sub(1'b1),
        .sum(neg_lo),
        .co (co_lo)
    );

    mult_seq_32_addsub u_neg_hi (
        .a  (~acc_q),
        .b  ({31'd0, mplr_zero}),
        .sub(1'b0),
        .sum(neg_hi),
        .co (co_hi)
    );

    assign unused_carries = &{co_na, co_nb, co_lo, co_hi};

    always_comb begin
        logic [31:0] sel_sum;
        logic        sel_co;

        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        sel_sum = acc_q;
        sel_co  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    mcand_d = A[31] ? neg_a : A;
                    mplr_d  = B[31] ? neg_b : B;
                    neg_d   = A[31] ^ B[31];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (mplr_q[0]) begin
                    sel_sum = step_sum;
                    sel_co  = step_co;
                end
                acc_d  = {sel_co, sel_sum[31:1]};
                mplr_d = {sel_sum[0], mplr_q[31:1]};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                if (neg_q) begin
                    hi_d = neg_hi;
                    lo_d = neg_lo;
                end else begin
                    hi_d = acc_q;
                    lo_d = mplr_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign DONE = done_q;
    assign BUSY = (state_q != S_IDLE);
endmodule

// File: tb/tb_mult_seq_32.sv
// Scoreboard bench for mult_seq_32: driver queues hand-computed products,
// a negedge monitor pops and compares on every DONE pulse.

module tb_mult_seq_32;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] HI, LO;
    logic        BUSY, DONE;
    logic [31:0] A, B;
    logic        START;

    int unsigned checks = 0;
    int unsigned passes = 0;
    logic [63:0] exp_q[$];

    mult_seq_32 dut (
        .CLK  (CLK),
        .RST  (RST),
        .HI   (HI),
        .LO   (LO),
        .BUSY (BUSY),
        .DONE (DONE),
        .A    (A),
        .B    (B),
        .START(START)
    );

    initial forever #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_without_request", {31'd0, DONE}, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("product_hi", HI, e[63:32]);
                check("product_lo", LO, e[31:0]);
            end
        end
    end

    // Drive one request; with sync_neg=0 the caller is already at a negedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                         input bit sync_neg, input bit hold);
        if (sync_neg) @(negedge CLK);
        A = a;
        B = b;
        START = 1'b1;
        @(posedge CLK);
        exp_q.push_back(exp);
        #1;
        if (!hold) START = 1'b0;
    endtask

    // Returns edges from acceptance to DONE and number of BUSY samples seen.
    task automatic wait_done(output int lat, output int busy_n,
                             input bit chk_hold, input logic [63:0] held);
        int n;
        n = 0;
        busy_n = 0;
        while (n < 80) begin
            @(negedge CLK);
            n++;
            if (DONE === 1'b1) break;
            if (BUSY === 1'b1) busy_n++;
            if (chk_hold) begin
                check("hold_hi", HI, held[63:32]);
                check("hold_lo", LO, held[31:0]);
            end
        end
        if (DONE !== 1'b1) check("done_timeout", {31'd0, DONE}, 32'd1);
        lat = n - 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time 100000 exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, bn, dn;
        RST = 1'b1;
        START = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);

        // Basic 3*5 with latency, BUSY width and single-cycle DONE
        issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1, 0);
        wait_done(lat, bn, 0, '0);
        check("basic_latency", lat, 33);
        check("basic_busy_cycles", bn, 33);
        check("basic_busy_at_done", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        check("basic_done_pulse", {31'd0, DONE}, 32'd0);

        // Asynchronous reset without a clock edge
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("async_rst_hi", HI, 32'h0);
        check("async_rst_lo", LO, 32'h0);
        check("async_rst_busy", {31'd0, BUSY}, 32'd0);
        check("async_rst_done", {31'd0, DONE}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        issue(32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        wait_done(lat, bn, 0, '0);
        issue(32'hFFFF_FFFE, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF2, 1, 0);
        wait_done(lat, bn, 0, '0);
        issue(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1, 0);
        wait_done(lat, bn, 0, '0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1, 0);
        wait_done(lat, bn, 0, '0);
        issue(32'h7FFF_FFFF, 32'h0000_0002, 64'h0000_0000_FFFF_FFFE, 1, 0);
        wait_done(lat, bn, 0, '0);

        // START pulse at edge k+5 must be ignored
        issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1, 0);
        repeat (4) @(posedge CLK);
        #1;
        A = 32'd7;
        B = 32'd9;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        wait_done(lat, bn, 0, '0);

        // START held through the DONE cycle: back-to-back, HI/LO hold old product
        A = 32'd2;
        B = 32'd3;
        START = 1'b1;
        @(posedge CLK);
        exp_q.push_back(64'h0000_0000_0000_0006);
        #1;
        check("b2b_busy", {31'd0, BUSY}, 32'd1);
        check("b2b_done_clear", {31'd0, DONE}, 32'd0);
        wait_done(lat, bn, 1, 64'h0000_0000_0000_000F);
        START = 1'b0;
        check("b2b_latency", lat, 33);
        @(negedge CLK);
        check("b2b_no_retrigger", {31'd0, BUSY}, 32'd0);

        // Reset mid-ITER after step 10 aborts with no DONE
        issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1, 0);
        repeat (10) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("abort_hi", HI, 32'h0);
        check("abort_lo", LO, 32'h0);
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        dn = 0;
        repeat (45) begin
            @(negedge CLK);
            if (DONE === 1'b1) dn++;
        end
        check("abort_no_done", dn, 0);

        // First START right after reset release, accepted on the next edge
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        issue(32'h7FFF_FFFF, 32'h0000_0002, 64'h0000_0000_FFFF_FFFE, 0, 0);
        wait_done(lat, bn, 0, '0);
        check("post_rst_latency", lat, 33);
        repeat (3) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mult_seq_32.md
# mult_seq_32

Sequential signed 32x32 multiplier that consumes the 32-bit ripple-carry adder/subtractor as its only arithmetic resource. It produces a 64-bit product split into HI and LO words. It sits beside the combinational ALU, which issues a start pulse and collects the result for the MUL instruction path. One product takes 33 clock cycles from the accepted start, using a shift-and-add datapath.

## Interface
- Parameters: none. Data width is fixed at 32 bits by the project data-width definition.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- HI  output  32  upper product word, registered.
- LO  output  32  lower product word, registered.
- BUSY  output  1  high while a multiply is in progress.
- DONE  output  1  one-cycle pulse; HI/LO hold a new valid product.
- A  input  32  multiplicand, signed two's complement.
- B  input  32  multiplier, signed two's complement.
- START  input  1  request; sampled only when BUSY=0.

## Operation
- States: IDLE, ITER, SIGN.
- IDLE:
  - On START=1, capture |A| into MCAND and |B| into MPLR.
  - Magnitudes come from the adder/subtractor in subtract mode (0 - x) when the operand's bit 31 is 1.
  - Capture NEG = A[31] XOR B[31].
  - Clear ACC (32 bits) and the 5-bit counter CNT.
  - Go to ITER.
- ITER, one step per cycle:
  - If MPLR[0]=1, sum = ACC + MCAND via the adder, with carry-out CO. Otherwise sum = ACC and CO=0.
  - {CO, sum, MPLR} shifts right by one: new ACC = {CO, sum[31:1]}, new MPLR = {sum[0], MPLR[31:1]}.
  - CNT increments by 1; after the step where CNT=31, go to SIGN.
- SIGN:
  - If NEG=0, {HI,LO} <= {ACC,MPLR}.
  - If NEG=1, {HI,LO} <= two's-complement negate of {ACC,MPLR}.
    - LO = 0 - MPLR.
    - HI = ~ACC + (MPLR==0 ? 1 : 0), built from adder instances.
  - DONE <= 1; return to IDLE.
- Width rules:
  - The magnitude of 0x80000000 is 0x80000000, treated as an unsigned 32-bit value.
  - The unsigned product fits in 64 bits; no overflow flag.
- HI/LO hold the last product until the next SIGN state or reset. They do not change during ITER.
- START while BUSY=1 is ignored; operands are not re-sampled.
- A and B may change freely after the accepting edge.
- Reset at any time, including mid-ITER, aborts the operation:
  - State=IDLE; CNT, ACC, MCAND, MPLR and NEG = 0.
  - HI=0, LO=0, BUSY=0, DONE=0.
- Reset values of every output: HI=0x00000000, LO=0x00000000, BUSY=0, DONE=0.

## Timing
- Edge k: START=1 sampled in IDLE and accepted. BUSY=1 from after edge k.
- Edges k+1 .. k+32: the 32 ITER steps.
- Edge k+33:
  - SIGN registers HI/LO and sets DONE=1.
  - BUSY falls to 0 in the same cycle.
- DONE is high for exactly the one cycle following edge k+33, then clears at edge k+34.
- Latency: the result is visible 33 cycles after the accepting edge.
- Back-to-back operation:
  - START held high during the DONE cycle is accepted at edge k+34.
  - DONE clears at that same edge.
  - Throughput is one product per 34 cycles.
- START=1 held continuously through a run causes exactly one operation per acceptance, never a re-trigger mid-run.
- The RST assertion takes effect immediately, without waiting for CLK.
- After RST deasserts, the first START can be accepted on the next rising edge.

## Test plan
- Reset: assert RST mid-cycle with no CLK edge -> HI=0, LO=0, BUSY=0, DONE=0 immediately. Also assert RST at ITER step 10 of 3*5 -> all zero, no DONE pulse follows.
- Basic: A=0x00000003, B=0x00000005, START at edge k -> DONE pulse after edge k+33, HI=0x00000000, LO=0x0000000F. BUSY is high for exactly 33 cycles.
- Sign mix: A=0xFFFFFFFF (-1), B=0x00000001 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- Sign mix: A=0xFFFFFFFE (-2), B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFF2.
- Extremes: A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
- Extremes: A=B=0xFFFFFFFF -> HI=0x00000000, LO=0x00000001.
- Extremes: A=0x7FFFFFFF, B=0x00000002 -> HI=0x00000000, LO=0xFFFFFFFE.
- Handshake:
  - Pulse START again at edge k+5 with A=7, B=9 during 3*5 -> ignored, result is 0x0F.
  - Hold START high with A=2, B=3 during the DONE cycle -> second operation accepted at edge k+34, DONE pulses again after edge k+67 with LO=0x00000006.
  - HI/LO keep 0x0F throughout the second run until it completes.
